// File: rtl/fsqrt_arbiter.sv
// fsqrt_arbiter: round-robin sharing of one fixed-latency fsqrt pipeline among NREQ requesters
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid_i, req_data_i        per-requester request valid and 32-bit operand
//   req_ready_o                    one-hot (or zero) accept for this cycle
//   resp_valid_o, resp_data_o      per-requester response FIFO non-empty and head
//   resp_ready_i                   per-requester FIFO pop
//   sqrt_a_o, sqrt_valid_o         registered issue to the fsqrt unit
//   sqrt_result_i, sqrt_out_valid_i  result returned by the fsqrt unit
//   idle_o                         no credit outstanding for any requester
//   err_o                          sticky tag/valid mismatch or FIFO overflow
module fsqrt_arbiter #(
   parameter int NREQ   = 2,
   parameter int LAT    = 3,
   parameter int RDEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid_i,
   input  logic [32*NREQ-1:0]   req_data_i,
   output logic [NREQ-1:0]      req_ready_o,
   output logic [NREQ-1:0]      resp_valid_o,
   output logic [32*NREQ-1:0]   resp_data_o,
   input  logic [NREQ-1:0]      resp_ready_i,
   output logic [31:0]          sqrt_a_o,
   output logic                 sqrt_valid_o,
   input  logic [31:0]          sqrt_result_i,
   input  logic                 sqrt_out_valid_i,
   output logic                 idle_o,
   output logic                 err_o
);
   localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam int AW = RDEPTH > 1 ? $clog2(RDEPTH) : 1;
   localparam int CW = $clog2(RDEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(RDEPTH);
   localparam logic [IW-1:0] LAST = IW'(NREQ - 1);
   logic [NREQ-1:0]       elig, wsel, ovf, busy;
   logic                  found, wb, err_q, err_d;
   logic [IW-1:0]         grant, rr_last_q;
   logic [31:0]           sqrt_a_q;
   // Stage 0 runs alongside the issue register, so stage LAT lines up with out_valid.
   logic [LAT:0]          tag_v_q;
   logic [LAT:0][IW-1:0]  tag_id_q;
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && elig[(int'(rr_last_q) + k) % NREQ]) begin
            found = 1'b1;
            grant = IW'((int'(rr_last_q) + k) % NREQ);
         end
      end
   end
   assign req_ready_o  = found ? NREQ'(1) << grant : '0;
   assign sqrt_valid_o = tag_v_q[0];
   assign sqrt_a_o     = sqrt_a_q;
   assign wb           = sqrt_out_valid_i & tag_v_q[LAT];
   assign err_d        = err_q | (tag_v_q[LAT] != sqrt_out_valid_i) | (|ovf);
   assign err_o        = err_q;
   assign idle_o       = ~|busy;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q <= LAST;
         sqrt_a_q  <= '0;
         tag_v_q   <= '0;
         tag_id_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         if (found) begin
            rr_last_q <= grant;
            sqrt_a_q  <= req_data_i[32*grant +: 32];
         end
         tag_v_q  <= {tag_v_q[LAT-1:0], found};
         tag_id_q <= {tag_id_q[LAT-1:0], grant};
         err_q    <= err_d;
      end
   end
   for (genvar g = 0; g < NREQ; g++) begin : g_req
      logic [CW-1:0] cnt_q, occ_q;
      logic [AW-1:0] wptr_q, rptr_q;
      logic [31:0]   mem_q [RDEPTH];
      logic          pop, push, full;
      assign full                    = occ_q == FULL;
      assign pop                     = resp_valid_o[g] & resp_ready_i[g];
      assign wsel[g]                 = wb && tag_id_q[LAT] == IW'(g);
      // A pop in the same cycle frees the slot, so a write into a full FIFO is still legal then.
      assign push                    = wsel[g] & (~full | pop);
      assign ovf[g]                  = wsel[g] & full & ~pop;
      // Credits cover in-flight ops plus FIFO occupancy, so an accepted op always has a slot.
      assign elig[g]                 = req_valid_i[g] && cnt_q != FULL;
      assign busy[g]                 = cnt_q != '0;
      assign resp_valid_o[g]         = occ_q != '0;
      assign resp_data_o[32*g +: 32] = mem_q[rptr_q];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q  <= '0;
            occ_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(req_ready_o[g]) - CW'(pop);
            occ_q <= occ_q + CW'(push) - CW'(pop);
            if (push) wptr_q <= wptr_q == AW'(RDEPTH - 1) ? '0 : wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q == AW'(RDEPTH - 1) ? '0 : rptr_q + 1'b1;
         end
      end
      always_ff @(posedge clk) begin
         if (push) mem_q[wptr_q] <= sqrt_result_i;
      end
   end
endmodule

// File: tb/tb_fsqrt_arbiter.sv
// tb_fsqrt_arbiter: randomized self-checking bench with a queue-based credit/round-robin model
module tb_fsqrt_arbiter;
   localparam int NREQ = 2, LAT = 3, RDEPTH = 4;
   logic clk = 1'b0, rst_n = 1'b0, force_ov = 1'b0;
   logic [NREQ-1:0] rv = '0, rr = '1, req_ready, resp_valid, last_ready;
   logic [32*NREQ-1:0] rd = '0, resp_data;
   logic [31:0] sqrt_a, sqrt_result;
   logic sqrt_valid, sov, idle, err;
   logic [LAT-1:0] pv;
   logic [31:0] pd [LAT];
   int checks = 0, failures = 0, cyc = 0;
   logic [63:0] q [NREQ][$];
   int rr_last = NREQ - 1;
   logic m_sv = 1'b0, m_err = 1'b0;
   logic [31:0] m_sa = '0;

   always #5 clk = ~clk;

   fsqrt_arbiter #(.NREQ(NREQ), .LAT(LAT), .RDEPTH(RDEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(rv), .req_data_i(rd), .req_ready_o(req_ready),
      .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_ready_i(rr),
      .sqrt_a_o(sqrt_a), .sqrt_valid_o(sqrt_valid),
      .sqrt_result_i(sqrt_result), .sqrt_out_valid_i(sov),
      .idle_o(idle), .err_o(err)
   );

   function automatic real f2d(input logic [31:0] f);
      logic [63:0] d;
      d = {f[31], {3'b0, f[30:23]} + 11'd896, f[22:0], 29'b0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] d2f(input real r);
      logic [63:0] d;
      d = $realtobits(r);
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   function automatic logic [31:0] fsq(input logic [31:0] a);
      return d2f($sqrt(f2d(a)));
   endfunction

   function automatic logic [31:0] sq_op();
      int k;
      k = int'($urandom_range(1, 4000));
      return d2f(real'(k * k));
   endfunction

   // Fixed-latency fsqrt unit: input_valid in cycle c gives out_valid in cycle c+LAT.
   assign sov = pv[LAT-1] | force_ov;
   assign sqrt_result = pd[LAT-1];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pv <= '0;
      else begin
         pv <= {pv[LAT-2:0], sqrt_valid};
         pd[0] <= fsq(sqrt_a);
         for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
      end
   end

   // One clock of the reference model: credits are queue sizes, each queue entry holds {due cycle, result}.
   task automatic step();
      int g;
      logic [NREQ-1:0] er, ev;
      logic busy;
      #1;
      g = -1;
      for (int k = 1; k <= NREQ; k++)
         if (g < 0 && rv[(rr_last + k) % NREQ] && q[(rr_last + k) % NREQ].size() < RDEPTH) g = (rr_last + k) % NREQ;
      er = (g < 0) ? '0 : NREQ'(1) << g;
      last_ready = req_ready;
      checks++;
      if (req_ready !== er) begin failures++; $display("FAIL grant cyc=%0d req_ready=%b expected=%b", cyc, req_ready, er); end
      busy = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         busy |= q[i].size() != 0;
         ev[i] = q[i].size() > 0 && int'(q[i][0][63:32]) <= cyc;
         checks++;
         if (resp_valid[i] !== ev[i]) begin failures++; $display("FAIL resp_valid[%0d] cyc=%0d got=%b expected=%b", i, cyc, resp_valid[i], ev[i]); end
         if (ev[i]) begin
            checks++;
            if (resp_data[32*i +: 32] !== q[i][0][31:0]) begin failures++; $display("FAIL resp_data[%0d] cyc=%0d got=%h expected=%h", i, cyc, resp_data[32*i +: 32], q[i][0][31:0]); end
         end
      end
      checks++;
      if (idle !== !busy) begin failures++; $display("FAIL idle cyc=%0d got=%b expected=%b", cyc, idle, !busy); end
      checks++;
      if (err !== m_err) begin failures++; $display("FAIL err cyc=%0d got=%b expected=%b", cyc, err, m_err); end
      checks++;
      if (sqrt_valid !== m_sv) begin failures++; $display("FAIL sqrt_valid cyc=%0d got=%b expected=%b", cyc, sqrt_valid, m_sv); end
      if (m_sv) begin
         checks++;
         if (sqrt_a !== m_sa) begin failures++; $display("FAIL sqrt_a cyc=%0d got=%h expected=%h", cyc, sqrt_a, m_sa); end
      end
      @(posedge clk);
      for (int i = 0; i < NREQ; i++) if (ev[i] && rr[i]) void'(q[i].pop_front());
      if (g >= 0) begin
         q[g].push_back({32'(cyc + LAT + 2), fsq(rd[32*g +: 32])});
         rr_last = g;
         m_sa = rd[32*g +: 32];
      end
      m_sv = g >= 0;
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rv = '0;
      rst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) q[i].delete();
      rr_last = NREQ - 1;
      m_sv = 1'b0;
      m_err = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      rv = '0;
      rr = '1;
      repeat (n) step();
   endtask

   task automatic test_reset();
      #1;
      checks += 6;
      if (req_ready !== '0) begin failures++; $display("FAIL rst_req_ready got=%b expected=0", req_ready); end
      if (sqrt_valid !== 1'b0) begin failures++; $display("FAIL rst_sqrt_valid got=%b expected=0", sqrt_valid); end
      if (sqrt_a !== '0) begin failures++; $display("FAIL rst_sqrt_a got=%h expected=0", sqrt_a); end
      if (resp_valid !== '0) begin failures++; $display("FAIL rst_resp_valid got=%b expected=0", resp_valid); end
      if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b expected=1", idle); end
      if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b expected=0", err); end
      do_reset();
      drain(2);
   endtask

   task automatic test_single_op();
      int t, first;
      logic [31:0] got;
      first = -1;
      got = '0;
      rr = '1;
      rv = 2'b01;
      rd[31:0] = 32'h40800000;
      t = cyc;
      step();
      rv = '0;
      checks++;
      if (sqrt_valid !== 1'b1) begin failures++; $display("FAIL single_issue sqrt_valid=%b expected=1", sqrt_valid); end
      for (int i = 0; i < 8; i++) begin
         if (first < 0 && resp_valid[0]) begin first = cyc; got = resp_data[31:0]; end
         step();
      end
      checks += 4;
      if (first != t + 5) begin failures++; $display("FAIL single_latency resp cycle=%0d expected=%0d", first, t + 5); end
      if (got !== 32'h40000000) begin failures++; $display("FAIL single_data got=%h expected=40000000", got); end
      if (idle !== 1'b1) begin failures++; $display("FAIL single_idle got=%b expected=1", idle); end
      if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b expected=0", err); end
   endtask

   task automatic test_contention();
      int n0, n1;
      logic [NREQ-1:0] eg;
      n0 = 0;
      n1 = 0;
      do_reset();
      rr = '1;
      rd = {32'h41800000, 32'h41100000};
      for (int c = 0; c < 18; c++) begin
         rv = c < 8 ? 2'b11 : 2'b00;
         if (resp_valid[0]) begin
            n0++; checks++;
            if (resp_data[31:0] !== 32'h40400000) begin failures++; $display("FAIL cont_data0 got=%h expected=40400000", resp_data[31:0]); end
         end
         if (resp_valid[1]) begin
            n1++; checks++;
            if (resp_data[63:32] !== 32'h40800000) begin failures++; $display("FAIL cont_data1 got=%h expected=40800000", resp_data[63:32]); end
         end
         step();
         if (c < 8) begin
            eg = (c % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (last_ready !== eg) begin failures++; $display("FAIL cont_grant c=%0d got=%b expected=%b", c, last_ready, eg); end
         end
      end
      checks += 2;
      if (n0 != 4) begin failures++; $display("FAIL cont_count0 got=%0d expected=4", n0); end
      if (n1 != 4) begin failures++; $display("FAIL cont_count1 got=%0d expected=4", n1); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ops [8];
      int acc_c [8];
      int idx, nresp;
      idx = 0;
      nresp = 0;
      rr = '1;
      for (int i = 0; i < 8; i++) ops[i] = sq_op();
      for (int c = 0; c < 40 && (idx < 8 || nresp < 8); c++) begin
         if (resp_valid[1]) begin
            checks++;
            if (nresp >= 8 || resp_data[63:32] !== fsq(ops[nresp % 8])) begin failures++; $display("FAIL b2b_order n=%0d got=%h", nresp, resp_data[63:32]); end
            nresp++;
         end
         rv = idx < 8 ? 2'b10 : 2'b00;
         if (idx < 8) rd[63:32] = ops[idx];
         step();
         if (idx < 8 && last_ready[1]) begin acc_c[idx] = c; idx++; end
      end
      checks += 2;
      if (idx != 8) begin failures++; $display("FAIL b2b_accepts got=%0d expected=8", idx); end
      if (nresp != 8) begin failures++; $display("FAIL b2b_results got=%0d expected=8", nresp); end
      for (int i = 0; i < RDEPTH && i < idx; i++) begin
         checks++;
         if (acc_c[i] != i) begin failures++; $display("FAIL b2b_stream i=%0d accept cycle=%0d expected=%0d", i, acc_c[i], i); end
      end
   endtask

   task automatic test_backpressure();
      int a0, a1;
      a0 = 0;
      a1 = 0;
      do_reset();
      rr = 2'b10;
      rv = 2'b11;
      for (int c = 0; c < 12; c++) begin
         rd = {sq_op(), sq_op()};
         step();
         a0 += int'(last_ready[0]);
         a1 += int'(last_ready[1]);
      end
      checks += 3;
      if (a0 != RDEPTH) begin failures++; $display("FAIL bp_accepts0 got=%0d expected=%0d", a0, RDEPTH); end
      if (last_ready[0] !== 1'b0) begin failures++; $display("FAIL bp_ready0 got=%b expected=0", last_ready[0]); end
      if (a1 == 0) begin failures++; $display("FAIL bp_served1 got=%0d expected>0", a1); end
      a0 = 0;
      rr = 2'b11;
      for (int c = 0; c < 9; c++) begin
         rd = {sq_op(), sq_op()};
         step();
         rr = 2'b10;
         a0 += int'(last_ready[0]);
      end
      checks++;
      if (a0 != 1) begin failures++; $display("FAIL bp_one_more got=%0d expected=1", a0); end
      drain(15);
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         rv = NREQ'($urandom);
         rr = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) rd[32*i +: 32] = sq_op();
         step();
      end
      drain(15);
   endtask

   task automatic test_error();
      force_ov = 1'b1;
      step();
      force_ov = 1'b0;
      m_err = 1'b1;
      checks++;
      if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b expected=1", err); end
      repeat (4) step();
      checks += 2;
      if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b expected=1", err); end
      if (resp_valid !== '0) begin failures++; $display("FAIL err_nowrite resp_valid=%b expected=0", resp_valid); end
   endtask

   task automatic test_reset_midflight();
      rr = '1;
      rv = 2'b01;
      repeat (3) begin
         rd[31:0] = sq_op();
         step();
      end
      rv = '0;
      rst_n = 1'b0;
      #1;
      checks += 4;
      if (sqrt_valid !== 1'b0) begin failures++; $display("FAIL mid_sqrt_valid got=%b expected=0", sqrt_valid); end
      if (resp_valid !== '0) begin failures++; $display("FAIL mid_resp_valid got=%b expected=0", resp_valid); end
      if (idle !== 1'b1) begin failures++; $display("FAIL mid_idle got=%b expected=1", idle); end
      if (err !== 1'b0) begin failures++; $display("FAIL mid_err got=%b expected=0", err); end
      do_reset();
      for (int c = 0; c < 8; c++) begin
         step();
         checks++;
         if (resp_valid !== '0) begin failures++; $display("FAIL mid_stale c=%0d resp_valid=%b expected=0", c, resp_valid); end
      end
      rv = 2'b11;
      rd = {sq_op(), sq_op()};
      step();
      checks++;
      if (last_ready !== 2'b01) begin failures++; $display("FAIL mid_first_grant got=%b expected=01", last_ready); end
      drain(10);
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_contention();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_error();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
